// File: rtl/exc_ctrl_if.sv
// Core-side signal bundle for the exception/interrupt controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle level signals.
interface exc_ctrl_if #(
    parameter int NUM_IRQ = 4,
    parameter int ADDR_W  = 64
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               bad_opcode;
    logic               eret;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  npc;
    logic               exc_take;
    logic [ADDR_W-1:0]  exc_vector;
    logic [ADDR_W-1:0]  elr;
    logic [3:0]         estatus;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               in_handler;
    logic               fault;

    modport master (
        output irq, irq_mask, bad_opcode, eret, pc, npc,
        input  exc_take, exc_vector, elr, estatus, irq_id, irq_pending, in_handler, fault
    );

    modport slave (
        input  irq, irq_mask, bad_opcode, eret, pc, npc,
        output exc_take, exc_vector, elr, estatus, irq_id, irq_pending, in_handler, fault
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: edge-latched maskable IRQs, ELR capture, handler FSM, watchdog.
// Latency: exc_take is combinational (0 cycles); IRQ edge to handler fetch is 2 cycles.
// Backpressure: none; requests stay pending while the FSM is busy or the channel is masked.
module exc_ctrl #(
    parameter int                NUM_IRQ     = 4,
    parameter int                ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(64'h0000_0000_0000_00D8),
    parameter int                WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);
    localparam int  ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int  WD_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam bit  WDOG_EN = (WDOG_CYCLES != 0);

    localparam logic [3:0] EST_NONE  = 4'b0000;
    localparam logic [3:0] EST_IRQ   = 4'b0001;
    localparam logic [3:0] EST_INVOP = 4'b0010;
    localparam logic [3:0] EST_DBL   = 4'b0011;
    localparam logic [3:0] EST_WDOG  = 4'b0100;

    typedef enum logic [1:0] {S_IDLE, S_HANDLER, S_COOLDOWN, S_FAULT} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] irq_prev, pending, pending_nxt, elig, clr;
    logic [ADDR_W-1:0]  elr;
    logic [3:0]         estatus, est_nxt;
    logic [ID_W-1:0]    irq_id, irq_sel;
    logic [WD_W-1:0]    wdog_cnt;
    logic               take_bad, take_irq, irq_hit;

    assign elig    = pending & bus.irq_mask;
    assign irq_hit = |elig;

    // Lowest eligible index wins: scan downward so the last hit is the smallest k.
    always_comb begin
        irq_sel = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig[k]) irq_sel = ID_W'(k);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        est_nxt   = estatus;
        take_bad  = 1'b0;
        take_irq  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.bad_opcode) begin
                    take_bad  = 1'b1;
                    est_nxt   = EST_INVOP;
                    state_nxt = S_HANDLER;
                end else if (irq_hit) begin
                    take_irq  = 1'b1;
                    est_nxt   = EST_IRQ;
                    state_nxt = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (bus.bad_opcode) begin
                    est_nxt   = EST_DBL;
                    state_nxt = S_FAULT;
                end else if (bus.eret) begin
                    est_nxt   = EST_NONE;
                    state_nxt = S_COOLDOWN;
                end else if (WDOG_EN && (wdog_cnt == WD_W'(WDOG_CYCLES - 1))) begin
                    est_nxt   = EST_WDOG;
                    state_nxt = S_FAULT;
                end
            end
            S_COOLDOWN: state_nxt = S_IDLE;
            default:    state_nxt = S_FAULT;
        endcase
    end

    // A new edge on a channel being taken this cycle survives the clear.
    always_comb begin
        clr = '0;
        if (take_irq) clr[irq_sel] = 1'b1;
        pending_nxt = (pending & ~clr) | (bus.irq & ~irq_prev);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev <= '0;
            pending  <= '0;
            elr      <= '0;
            estatus  <= EST_NONE;
            irq_id   <= '0;
            wdog_cnt <= '0;
        end else begin
            irq_prev <= bus.irq;
            pending  <= pending_nxt;
            estatus  <= est_nxt;
            if (take_bad) begin
                elr <= bus.pc;
            end else if (take_irq) begin
                elr    <= bus.npc;
                irq_id <= irq_sel;
            end
            // Held at zero outside HANDLER, so each entry starts a fresh count.
            if (state == S_HANDLER) wdog_cnt <= wdog_cnt + WD_W'(1);
            else                    wdog_cnt <= '0;
        end
    end

    assign bus.exc_take    = reset & (take_bad | take_irq);
    assign bus.exc_vector  = EXC_VEC;
    assign bus.elr         = elr;
    assign bus.estatus     = estatus;
    assign bus.irq_id      = irq_id;
    assign bus.irq_pending = pending;
    assign bus.in_handler  = (state == S_HANDLER);
    assign bus.fault       = (state == S_FAULT);
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_exc_ctrl;
    localparam int          N   = 4;
    localparam int          AW  = 64;
    localparam int          WD  = 8;
    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    localparam int M_IDLE = 0, M_HND = 1, M_COOL = 2, M_FLT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    exc_ctrl_if #(.NUM_IRQ(N), .ADDR_W(AW)) bus ();

    exc_ctrl #(.NUM_IRQ(N), .ADDR_W(AW), .EXC_VEC(VEC), .WDOG_CYCLES(WD)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state: which mode we are in and how many handler cycles have elapsed.
    int          m_mode = M_IDLE;
    int          m_hc   = 0;
    logic [3:0]  m_pend = '0;
    logic [3:0]  m_prev = '0;
    logic [63:0] m_elr  = '0;
    logic [3:0]  m_est  = '0;
    int          m_id   = 0;

    function automatic logic m_take();
        return rst_n && (m_mode == M_IDLE) && (bus.bad_opcode || ((m_pend & bus.irq_mask) != 4'b0));
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] rise;
        logic [3:0] elig;
        int         k;
        if (!rst_n) begin
            m_mode = M_IDLE; m_hc = 0; m_pend = '0; m_prev = '0;
            m_elr = '0; m_est = '0; m_id = 0;
        end else begin
            rise = bus.irq & ~m_prev;
            elig = m_pend & bus.irq_mask;
            case (m_mode)
                M_IDLE: begin
                    if (bus.bad_opcode) begin
                        m_elr = bus.pc; m_est = 4'd2; m_mode = M_HND; m_hc = 0;
                    end else if (elig != 4'b0) begin
                        k = 0;
                        while (!elig[k]) k++;
                        m_elr = bus.npc; m_est = 4'd1; m_id = k;
                        m_pend[k] = 1'b0;
                        m_mode = M_HND; m_hc = 0;
                    end
                end
                M_HND: begin
                    m_hc++;
                    if (bus.bad_opcode) begin
                        m_est = 4'd3; m_mode = M_FLT;
                    end else if (bus.eret) begin
                        m_est = 4'd0; m_mode = M_COOL;
                    end else if (WD != 0 && m_hc == WD) begin
                        m_est = 4'd4; m_mode = M_FLT;
                    end
                end
                M_COOL:  m_mode = M_IDLE;
                default: m_mode = M_FLT;
            endcase
            m_pend = m_pend | rise;
            m_prev = bus.irq;
        end
    end

    always @(negedge clk) begin
        chk("exc_take",    bus.exc_take,    m_take());
        chk("exc_vector",  bus.exc_vector,  VEC);
        chk("elr",         bus.elr,         m_elr);
        chk("estatus",     bus.estatus,     m_est);
        chk("irq_id",      bus.irq_id,      m_id);
        chk("irq_pending", bus.irq_pending, m_pend);
        chk("in_handler",  bus.in_handler,  m_mode == M_HND);
        chk("fault",       bus.fault,       m_mode == M_FLT);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_take"},  bus.exc_take,    0);
        chk({tag, "_elr"},   bus.elr,         0);
        chk({tag, "_est"},   bus.estatus,     0);
        chk({tag, "_id"},    bus.irq_id,      0);
        chk({tag, "_pend"},  bus.irq_pending, 0);
        chk({tag, "_inh"},   bus.in_handler,  0);
        chk({tag, "_fault"}, bus.fault,       0);
    endtask

    initial begin
        bus.irq = '0; bus.irq_mask = '0; bus.bad_opcode = 1'b0; bus.eret = 1'b0;
        bus.pc = '0; bus.npc = '0;

        // Reset, including exc_take held low against bad_opcode
        #1 rst_n = 1'b0;
        #1 chk_zero("rst");
        bus.bad_opcode = 1'b1;
        #1 chk("rst_take_forced", bus.exc_take, 0);
        bus.bad_opcode = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // IRQ take on channel 2
        bus.irq_mask = 4'hF; bus.pc = 64'h40; bus.npc = 64'h44; bus.irq = 4'b0100;
        tick();
        bus.irq = '0;
        #1 chk("t1_take", bus.exc_take, 1);
        chk("t1_pend_set", bus.irq_pending, 4'b0100);
        tick(); #1;
        chk("t1_elr", bus.elr, 64'h44);
        chk("t1_est", bus.estatus, 4'b0001);
        chk("t1_id", bus.irq_id, 2);
        chk("t1_inh", bus.in_handler, 1);
        chk("t1_pend_clr", bus.irq_pending, 0);
        chk("t1_take_off", bus.exc_take, 0);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        #1 chk("t1_cool_inh", bus.in_handler, 0);
        chk("t1_cool_est", bus.estatus, 0);
        chk("t1_cool_elr", bus.elr, 64'h44);
        tick();

        // Priority and masking
        bus.irq_mask = 4'b1101; bus.irq = 4'b1010;
        tick();
        bus.irq = '0;
        #1 chk("t2_take", bus.exc_take, 1);
        tick(); #1;
        chk("t2_id3", bus.irq_id, 3);
        chk("t2_pend1", bus.irq_pending, 4'b0010);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        #1 chk("t2_cool_take", bus.exc_take, 0);
        tick(); #1;
        chk("t2_masked_take", bus.exc_take, 0);
        chk("t2_masked_pend", bus.irq_pending, 4'b0010);
        bus.irq_mask = 4'hF;
        #1 chk("t2_unmask_take", bus.exc_take, 1);
        tick(); #1;
        chk("t2_id1", bus.irq_id, 1);
        chk("t2_inh", bus.in_handler, 1);
        chk("t2_pend0", bus.irq_pending, 0);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        tick();

        // Invalid opcode beats an eligible IRQ
        bus.irq = 4'b0001;
        tick();
        bus.irq = '0; bus.pc = 64'h80; bus.npc = 64'h84; bus.bad_opcode = 1'b1;
        #1 chk("t3_take", bus.exc_take, 1);
        tick();
        bus.bad_opcode = 1'b0;
        #1 chk("t3_elr", bus.elr, 64'h80);
        chk("t3_est", bus.estatus, 4'b0010);
        chk("t3_pend", bus.irq_pending, 4'b0001);
        chk("t3_inh", bus.in_handler, 1);

        // Double fault: bad_opcode and eret together in HANDLER
        bus.bad_opcode = 1'b1; bus.eret = 1'b1;
        tick();
        bus.bad_opcode = 1'b0; bus.eret = 1'b0;
        #1 chk("t4_fault", bus.fault, 1);
        chk("t4_est", bus.estatus, 4'b0011);
        chk("t4_take", bus.exc_take, 0);
        for (int i = 0; i < 6; i++) begin
            bus.irq = i[0] ? 4'hF : 4'h0;
            bus.bad_opcode = i[0];
            tick(); #1;
            chk("t4_sticky_take", bus.exc_take, 0);
            chk("t4_sticky_fault", bus.fault, 1);
            chk("t4_sticky_est", bus.estatus, 4'b0011);
        end
        bus.irq = '0; bus.bad_opcode = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero("t4_rst");
        tick();
        rst_n = 1'b1;

        // Watchdog: enter handler and never eret
        bus.irq = 4'b0001;
        tick();
        bus.irq = '0;
        tick(); #1;
        chk("t5_inh_first", bus.in_handler, 1);
        repeat (7) tick();
        #1 chk("t5_inh_8th", bus.in_handler, 1);
        chk("t5_nofault_8th", bus.fault, 0);
        tick(); #1;
        chk("t5_fault", bus.fault, 1);
        chk("t5_est", bus.estatus, 4'b0100);

        // Async reset mid-handler with requests pending
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.irq = 4'b0010;
        tick();
        bus.irq = '0;
        tick(); #1;
        chk("t6_inh", bus.in_handler, 1);
        bus.irq = 4'b0101;
        tick(); #1;
        chk("t6_pend", bus.irq_pending, 4'b0101);
        chk("t6_inh2", bus.in_handler, 1);
        bus.irq = '0;
        #1 rst_n = 1'b0;
        #1 chk_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick(); #1;
            chk("t6_post_take", bus.exc_take, 0);
            chk("t6_post_pend", bus.irq_pending, 0);
            chk("t6_post_inh", bus.in_handler, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
